// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF types plus the result-tracker entry types.
// Widths here are the single source for every tracker instance.
package cv32e40px_core_v_xif_pkg;

  localparam int XLEN        = 32;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]         id;
    logic [X_RFW_WIDTH-1:0]        data;
    logic [4:0]                    rd;
    logic [X_RFW_WIDTH/XLEN-1:0]   we;
    logic [5:0]                    ecsdata;
    logic [2:0]                    ecswe;
    logic                          exc;
    logic [5:0]                    exccode;
    logic                          err;
    logic                          dbg;
  } x_result_t;

  // FREE must stay the all-zero encoding so a cleared entry is free.
  typedef enum logic [1:0] {
    X_TRK_FREE      = 2'd0,
    X_TRK_ISSUED    = 2'd1,
    X_TRK_COMMITTED = 2'd2,
    X_TRK_KILLED    = 2'd3
  } x_trk_state_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [4:0]             rd;
    logic                   wb;
    logic [X_RFW_WIDTH-1:0] data;
    logic                   exc;
    logic [5:0]             exccode;
    x_trk_state_e           state;
    logic                   done;
  } x_trk_entry_t;

endpackage

// File: rtl/cv32e40px_xif_result_tracker.sv
// In-order tracker pairing coprocessor results with commits; result one cycle after exec.
// Holds result_valid_o until result_ready_i; alloc_ready_o drops when all DEPTH entries are in use.
module cv32e40px_xif_result_tracker
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  input  logic [X_ID_WIDTH-1:0]         alloc_id_i,
  input  logic [4:0]                    alloc_rd_i,
  input  logic                          alloc_wb_i,
  input  logic                          commit_valid_i,
  input  x_commit_t                     commit_i,
  input  logic                          exec_valid_i,
  input  logic [X_ID_WIDTH-1:0]         exec_id_i,
  input  logic [X_RFW_WIDTH-1:0]        exec_data_i,
  input  logic                          exec_exc_i,
  input  logic [5:0]                    exec_exccode_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output x_result_t                     result_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  x_trk_entry_t ent [DEPTH];
  x_trk_entry_t head_ent;
  x_trk_state_e commit_state;
  logic         alloc_fire;
  logic         kill_retire;
  logic         retire;
  logic         alloc_dup;

  // Registered count only: a slot freed this cycle is reusable next cycle.
  assign alloc_ready_o  = (count_q < DEPTH_C);
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;
  assign head_ent       = ent[head_q];
  assign result_valid_o = (head_ent.state == X_TRK_COMMITTED) && head_ent.done;
  assign kill_retire    = (head_ent.state == X_TRK_KILLED) && head_ent.done;
  assign retire         = (result_valid_o && result_ready_i) || kill_retire;
  assign commit_state   = commit_i.commit_kill ? X_TRK_KILLED : X_TRK_COMMITTED;
  assign count_o        = count_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    x_trk_entry_t ent_q, ent_d;
    logic alloc_here, retire_here, commit_hit, exec_hit;

    // A commit/exec for the id being allocated right now lands on the new entry.
    always_comb begin
      alloc_here  = alloc_fire && (tail_q == PTR_W'(g));
      retire_here = retire && (head_q == PTR_W'(g));
      commit_hit  = commit_valid_i &&
                    (alloc_here ? (commit_i.id == alloc_id_i)
                                : ((ent_q.state == X_TRK_ISSUED) && (commit_i.id == ent_q.id)));
      exec_hit    = exec_valid_i &&
                    (alloc_here ? (exec_id_i == alloc_id_i)
                                : ((ent_q.state != X_TRK_FREE) && !retire_here &&
                                   (exec_id_i == ent_q.id)));
      ent_d = ent_q;
      if (alloc_here) begin
        ent_d.id    = alloc_id_i;
        ent_d.rd    = alloc_rd_i;
        ent_d.wb    = alloc_wb_i;
        ent_d.state = X_TRK_ISSUED;
        ent_d.done  = 1'b0;
      end else if (retire_here) begin
        ent_d.state = X_TRK_FREE;
        ent_d.done  = 1'b0;
      end
      if (commit_hit) begin
        ent_d.state = commit_state;
      end
      if (exec_hit) begin
        ent_d.data    = exec_data_i;
        ent_d.exc     = exec_exc_i;
        ent_d.exccode = exec_exccode_i;
        ent_d.done    = 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign ent[g] = ent_q;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc_fire) begin
      tail_d = tail_q + 1'b1;
    end
    if (retire) begin
      head_d = head_q + 1'b1;
    end
    if (alloc_fire && !retire) begin
      count_d = count_q + 1'b1;
    end else if (!alloc_fire && retire) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    result_o         = '0;
    result_o.id      = head_ent.id;
    result_o.data    = head_ent.data;
    result_o.rd      = head_ent.rd;
    result_o.we[0]   = head_ent.wb && !head_ent.exc;
    result_o.exc     = head_ent.exc;
    result_o.exccode = head_ent.exccode;
  end

  // Ids must be unique among live entries; a duplicate would make matching ambiguous.
  always_comb begin
    alloc_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ent[i].state != X_TRK_FREE) && (ent[i].id == alloc_id_i)) begin
        alloc_dup = 1'b1;
      end
    end
  end

  a_alloc_unique_id : assert property (@(posedge clk_i) disable iff (rst_i)
    alloc_fire |-> !alloc_dup);

endmodule

// File: tb/tb_cv32e40px_xif_result_tracker.sv
// Directed bench for the XIF result tracker; inputs change 1 ns after posedge,
// outputs are checked at the same point.
module tb_cv32e40px_xif_result_tracker;
  import cv32e40px_core_v_xif_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   alloc_valid_i, alloc_ready_o, alloc_wb_i;
  logic [X_ID_WIDTH-1:0]  alloc_id_i;
  logic [4:0]             alloc_rd_i;
  logic                   commit_valid_i;
  x_commit_t              commit_i;
  logic                   exec_valid_i, exec_exc_i;
  logic [X_ID_WIDTH-1:0]  exec_id_i;
  logic [X_RFW_WIDTH-1:0] exec_data_i;
  logic [5:0]             exec_exccode_i;
  logic                   result_valid_o, result_ready_i;
  x_result_t              result_o;
  logic [2:0]             count_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  cv32e40px_xif_result_tracker #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_id_i     (alloc_id_i),
    .alloc_rd_i     (alloc_rd_i),
    .alloc_wb_i     (alloc_wb_i),
    .commit_valid_i (commit_valid_i),
    .commit_i       (commit_i),
    .exec_valid_i   (exec_valid_i),
    .exec_id_i      (exec_id_i),
    .exec_data_i    (exec_data_i),
    .exec_exc_i     (exec_exc_i),
    .exec_exccode_i (exec_exccode_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    alloc_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    exec_valid_i   = 1'b0;
    exec_exc_i     = 1'b0;
    exec_exccode_i = 6'd0;
  endtask

  task automatic set_alloc(input logic [3:0] id, input logic [4:0] rd, input logic wb);
    alloc_valid_i = 1'b1;
    alloc_id_i    = id;
    alloc_rd_i    = rd;
    alloc_wb_i    = wb;
  endtask

  task automatic set_commit(input logic [3:0] id, input logic kill);
    commit_valid_i       = 1'b1;
    commit_i.id          = id;
    commit_i.commit_kill = kill;
  endtask

  task automatic set_exec(input logic [3:0] id, input logic [31:0] data,
                          input logic exc, input logic [5:0] code);
    exec_valid_i   = 1'b1;
    exec_id_i      = id;
    exec_data_i    = data;
    exec_exc_i     = exc;
    exec_exccode_i = code;
  endtask

  initial begin
    rst_i          = 1'b1;
    result_ready_i = 1'b0;
    alloc_id_i     = '0;
    alloc_rd_i     = '0;
    alloc_wb_i     = 1'b0;
    commit_i       = '0;
    exec_id_i      = '0;
    exec_data_i    = '0;
    idle();
    tick();
    tick();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_rvalid", 64'(result_valid_o), 64'd0);
    check("rst_aready", 64'(alloc_ready_o), 64'd1);
    rst_i = 1'b0;

    // Basic flow: result appears exactly one cycle after exec.
    set_alloc(4'd3, 5'd5, 1'b1); tick(); idle();
    check("s1_count", 64'(count_o), 64'd1);
    set_commit(4'd3, 1'b0); tick(); idle();
    check("s1_rvalid_pre", 64'(result_valid_o), 64'd0);
    result_ready_i = 1'b1;
    set_exec(4'd3, 32'hDEADBEEF, 1'b0, 6'd0); tick(); idle();
    check("s1_rvalid", 64'(result_valid_o), 64'd1);
    check("s1_id", 64'(result_o.id), 64'd3);
    check("s1_data", 64'(result_o.data), 64'hDEADBEEF);
    check("s1_we", 64'(result_o.we), 64'd1);
    check("s1_rd", 64'(result_o.rd), 64'd5);
    check("s1_exc", 64'(result_o.exc), 64'd0);
    check("s1_zero_ecs", 64'({result_o.ecsdata, result_o.ecswe, result_o.err, result_o.dbg}), 64'd0);
    tick();
    check("s1_rvalid_post", 64'(result_valid_o), 64'd0);
    check("s1_count_post", 64'(count_o), 64'd0);

    // Out-of-order exec still retires in allocation order.
    result_ready_i = 1'b0;
    set_alloc(4'd1, 5'd1, 1'b1); tick();
    set_alloc(4'd2, 5'd2, 1'b1); tick(); idle();
    set_exec(4'd2, 32'h22, 1'b0, 6'd0); tick(); idle();
    check("s2_rvalid_early", 64'(result_valid_o), 64'd0);
    set_exec(4'd1, 32'h11, 1'b0, 6'd0); tick(); idle();
    set_commit(4'd1, 1'b0); tick(); idle();
    set_commit(4'd2, 1'b0); tick(); idle();
    check("s2_rvalid_a", 64'(result_valid_o), 64'd1);
    check("s2_id_a", 64'(result_o.id), 64'd1);
    check("s2_data_a", 64'(result_o.data), 64'h11);
    check("s2_count", 64'(count_o), 64'd2);
    result_ready_i = 1'b1; tick();
    check("s2_rvalid_b", 64'(result_valid_o), 64'd1);
    check("s2_id_b", 64'(result_o.id), 64'd2);
    check("s2_data_b", 64'(result_o.data), 64'h22);
    tick();
    check("s2_rvalid_end", 64'(result_valid_o), 64'd0);
    check("s2_count_end", 64'(count_o), 64'd0);

    // Killed instruction retires silently.
    set_alloc(4'd5, 5'd3, 1'b1); tick(); idle();
    set_commit(4'd5, 1'b1); tick(); idle();
    set_exec(4'd5, 32'h55, 1'b0, 6'd0); tick(); idle();
    check("s3_rvalid_a", 64'(result_valid_o), 64'd0);
    tick();
    check("s3_rvalid_b", 64'(result_valid_o), 64'd0);
    check("s3_count", 64'(count_o), 64'd0);

    // Alloc, commit and exec of one id in the same cycle.
    result_ready_i = 1'b0;
    set_alloc(4'd6, 5'd6, 1'b1); set_commit(4'd6, 1'b0);
    set_exec(4'd6, 32'h66, 1'b0, 6'd0); tick(); idle();
    check("s4_rvalid", 64'(result_valid_o), 64'd1);
    check("s4_id", 64'(result_o.id), 64'd6);
    check("s4_data", 64'(result_o.data), 64'h66);
    result_ready_i = 1'b1; tick();
    check("s4_count", 64'(count_o), 64'd0);

    // Full FIFO with pointer wrap; a retiring slot is reusable only next cycle.
    for (int i = 0; i < 4; i++) begin
      set_alloc(4'(8 + i), 5'(i), 1'b1); tick();
    end
    idle();
    check("s5_count_full", 64'(count_o), 64'd4);
    check("s5_aready_full", 64'(alloc_ready_o), 64'd0);
    set_alloc(4'd12, 5'd0, 1'b1); tick(); idle();
    check("s5_count_blocked", 64'(count_o), 64'd4);
    set_commit(4'd8, 1'b0); set_exec(4'd8, 32'h88, 1'b0, 6'd0); tick(); idle();
    check("s5_rvalid", 64'(result_valid_o), 64'd1);
    check("s5_aready_retire", 64'(alloc_ready_o), 64'd0);
    tick();
    check("s5_aready_after", 64'(alloc_ready_o), 64'd1);
    check("s5_count_after", 64'(count_o), 64'd3);
    for (int i = 9; i < 12; i++) begin
      set_commit(4'(i), 1'b0); set_exec(4'(i), 32'(i), 1'b0, 6'd0); tick();
    end
    idle();
    tick();
    tick();
    check("s5_count_drain", 64'(count_o), 64'd0);

    // Exception suppresses the register write.
    result_ready_i = 1'b0;
    set_alloc(4'd7, 5'd9, 1'b1); tick(); idle();
    set_commit(4'd7, 1'b0); tick(); idle();
    set_exec(4'd7, 32'h1234, 1'b1, 6'd2); tick(); idle();
    check("s6_rvalid", 64'(result_valid_o), 64'd1);
    check("s6_exc", 64'(result_o.exc), 64'd1);
    check("s6_exccode", 64'(result_o.exccode), 64'd2);
    check("s6_we", 64'(result_o.we), 64'd0);
    check("s6_rd", 64'(result_o.rd), 64'd9);
    result_ready_i = 1'b1; tick();
    check("s6_count", 64'(count_o), 64'd0);

    // Reset with three entries outstanding, head already presentable.
    result_ready_i = 1'b0;
    set_alloc(4'd1, 5'd1, 1'b1); set_commit(4'd1, 1'b0);
    set_exec(4'd1, 32'hAA, 1'b0, 6'd0); tick(); idle();
    set_alloc(4'd2, 5'd2, 1'b1); tick();
    set_alloc(4'd3, 5'd3, 1'b1); tick(); idle();
    check("s7_count_pre", 64'(count_o), 64'd3);
    check("s7_rvalid_pre", 64'(result_valid_o), 64'd1);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("s7_count_rst", 64'(count_o), 64'd0);
    check("s7_rvalid_rst", 64'(result_valid_o), 64'd0);
    check("s7_aready_rst", 64'(alloc_ready_o), 64'd1);
    result_ready_i = 1'b1;
    set_commit(4'd2, 1'b0); set_exec(4'd2, 32'hBB, 1'b0, 6'd0); tick(); idle();
    check("s7_stale_rvalid", 64'(result_valid_o), 64'd0);
    check("s7_stale_count", 64'(count_o), 64'd0);
    result_ready_i = 1'b0;
    set_alloc(4'd4, 5'd4, 1'b1); set_commit(4'd4, 1'b0);
    set_exec(4'd4, 32'hCC, 1'b0, 6'd0); tick(); idle();
    check("s7_fresh_rvalid", 64'(result_valid_o), 64'd1);
    check("s7_fresh_id", 64'(result_o.id), 64'd4);
    check("s7_fresh_data", 64'(result_o.data), 64'hCC);
    result_ready_i = 1'b1; tick();
    check("s7_fresh_count", 64'(count_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
